// File: rtl/ysyx_25030081_rf_wb_arb.sv
// Write-back arbiter for the single GPR write port (ex vs lsu, round-robin) plus RAW scoreboard.
// Optional macro YSYX_25030081_WB_BYPASS_EN: masks busy for a register being written this cycle and exports its data.
module ysyx_25030081_rf_wb_arb #(
    parameter int RF_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_stall,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [RF_ADDR_WIDTH-1:0] ex_waddr,
    input  logic [DATA_WIDTH-1:0]    ex_wdata,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [RF_ADDR_WIDTH-1:0] lsu_waddr,
    input  logic [DATA_WIDTH-1:0]    lsu_wdata,
    output logic                     rf_wen,
    output logic [RF_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    input  logic                     sb_set,
    input  logic [RF_ADDR_WIDTH-1:0] sb_set_addr,
    input  logic [RF_ADDR_WIDTH-1:0] sb_raddr1,
    input  logic [RF_ADDR_WIDTH-1:0] sb_raddr2,
    output logic                     sb_busy1,
    output logic                     sb_busy2,
    output logic [31:0]              wb_cnt
`ifdef YSYX_25030081_WB_BYPASS_EN
    ,
    output logic [DATA_WIDTH-1:0]    bypass_data1,
    output logic [DATA_WIDTH-1:0]    bypass_data2
`endif
);

    localparam logic GRANT_EX  = 1'b0;
    localparam logic GRANT_LSU = 1'b1;
    localparam int   NUM_REGS  = 1 << RF_ADDR_WIDTH;

    logic                     r_last_grant;
    logic                     r_rf_wen;
    logic [RF_ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0]    r_rf_wdata;
    logic [31:0]              r_wb_cnt;
    logic [NUM_REGS-1:0]      r_busy;

    logic                     w_ex_grant;
    logic                     w_lsu_grant;
    logic                     w_xfer;
    logic [RF_ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0]    w_sel_data;
    logic [NUM_REGS-1:0]      w_busy_nxt;
    logic                     w_raw_busy1;
    logic                     w_raw_busy2;

    // On a conflict the producer that did not win last time gets the port.
    always_comb begin
        w_ex_grant  = 1'b0;
        w_lsu_grant = 1'b0;
        if (!wb_stall) begin
            if (ex_valid && lsu_valid) begin
                w_ex_grant  = (r_last_grant == GRANT_LSU);
                w_lsu_grant = (r_last_grant == GRANT_EX);
            end else begin
                w_ex_grant  = ex_valid;
                w_lsu_grant = lsu_valid;
            end
        end
    end

    assign ex_ready   = w_ex_grant;
    assign lsu_ready  = w_lsu_grant;
    assign w_xfer     = w_ex_grant | w_lsu_grant;
    assign w_sel_addr = w_ex_grant ? ex_waddr : lsu_waddr;
    assign w_sel_data = w_ex_grant ? ex_wdata : lsu_wdata;

    // A new producer issued in the same cycle as the old one retires keeps the register busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_rf_wen) begin
            w_busy_nxt[r_rf_waddr] = 1'b0;
        end
        if (sb_set && (sb_set_addr != '0)) begin
            w_busy_nxt[sb_set_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GRANT_LSU;
            r_rf_wen     <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_wb_cnt     <= '0;
            r_busy       <= '0;
        end else begin
            r_rf_wen <= w_xfer && (w_sel_addr != '0);
            if (w_xfer) begin
                r_last_grant <= w_ex_grant ? GRANT_EX : GRANT_LSU;
                r_rf_waddr   <= w_sel_addr;
                r_rf_wdata   <= w_sel_data;
            end
            if (r_rf_wen) begin
                r_wb_cnt <= r_wb_cnt + 32'd1;
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign rf_wen      = r_rf_wen;
    assign rf_waddr    = r_rf_waddr;
    assign rf_wdata    = r_rf_wdata;
    assign wb_cnt      = r_wb_cnt;
    assign w_raw_busy1 = r_busy[sb_raddr1];
    assign w_raw_busy2 = r_busy[sb_raddr2];

`ifdef YSYX_25030081_WB_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    assign w_byp1       = r_rf_wen && (r_rf_waddr == sb_raddr1) && !(sb_set && (sb_set_addr == sb_raddr1));
    assign w_byp2       = r_rf_wen && (r_rf_waddr == sb_raddr2) && !(sb_set && (sb_set_addr == sb_raddr2));
    assign sb_busy1     = w_raw_busy1 & ~w_byp1;
    assign sb_busy2     = w_raw_busy2 & ~w_byp2;
    assign bypass_data1 = r_rf_wdata;
    assign bypass_data2 = r_rf_wdata;
`else
    assign sb_busy1 = w_raw_busy1;
    assign sb_busy2 = w_raw_busy2;
`endif

endmodule

// File: tb/tb_ysyx_25030081_rf_wb_arb.sv
// Directed and randomized bench for the write-back arbiter, checked against a cycle-level reference model.
module tb_ysyx_25030081_rf_wb_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_stall = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [4:0]  ex_waddr = '0;
    logic [31:0] ex_wdata = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_waddr = '0;
    logic [31:0] lsu_wdata = '0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_set_addr = '0;
    logic [4:0]  sb_raddr1 = '0;
    logic [4:0]  sb_raddr2 = '0;
    logic        sb_busy1;
    logic        sb_busy2;
    logic [31:0] wb_cnt;
`ifdef YSYX_25030081_WB_BYPASS_EN
    logic [31:0] bypass_data1;
    logic [31:0] bypass_data2;
`endif

    ysyx_25030081_rf_wb_arb dut (
        .clk(clk), .rst(rst), .wb_stall(wb_stall),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_raddr1(sb_raddr1), .sb_raddr2(sb_raddr2),
        .sb_busy1(sb_busy1), .sb_busy2(sb_busy2), .wb_cnt(wb_cnt)
`ifdef YSYX_25030081_WB_BYPASS_EN
        , .bypass_data1(bypass_data1), .bypass_data2(bypass_data2)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: who won last, the pending write, the retired count, and pending producers
    bit          m_last_lsu;
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_cnt;
    bit          m_busy [32];

    logic obs_ex_rdy, obs_lsu_rdy, obs_b1, obs_b2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_lsu = 1'b1;
        m_wen      = 1'b0;
        m_waddr    = '0;
        m_wdata    = '0;
        m_cnt      = '0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    function automatic bit bypass_hit(input logic [4:0] ra);
`ifdef YSYX_25030081_WB_BYPASS_EN
        return m_wen && (m_waddr == ra) && !(sb_set && (sb_set_addr == ra));
`else
        return 1'b0;
`endif
    endfunction

    // One clock: check combinational outputs before the edge, advance the model, check registered outputs after.
    task automatic cycle();
        int winner;
        #1;
        winner = 0;
        if (!wb_stall) begin
            if (ex_valid && lsu_valid) winner = m_last_lsu ? 1 : 2;
            else if (ex_valid)         winner = 1;
            else if (lsu_valid)        winner = 2;
        end
        obs_ex_rdy  = ex_ready;
        obs_lsu_rdy = lsu_ready;
        obs_b1      = sb_busy1;
        obs_b2      = sb_busy2;
        chk("ex_ready", ex_ready, 32'(winner == 1));
        chk("lsu_ready", lsu_ready, 32'(winner == 2));
        chk("sb_busy1", sb_busy1, 32'(m_busy[sb_raddr1] && !bypass_hit(sb_raddr1)));
        chk("sb_busy2", sb_busy2, 32'(m_busy[sb_raddr2] && !bypass_hit(sb_raddr2)));
`ifdef YSYX_25030081_WB_BYPASS_EN
        if (bypass_hit(sb_raddr1)) chk("bypass_data1", bypass_data1, m_wdata);
        if (bypass_hit(sb_raddr2)) chk("bypass_data2", bypass_data2, m_wdata);
`endif
        @(posedge clk);
        if (m_wen) begin
            m_cnt = m_cnt + 32'd1;
            m_busy[m_waddr] = 1'b0;
        end
        if (sb_set && sb_set_addr != 5'd0) m_busy[sb_set_addr] = 1'b1;
        if (winner == 1) begin
            m_wen = (ex_waddr != 5'd0); m_waddr = ex_waddr; m_wdata = ex_wdata; m_last_lsu = 1'b0;
        end else if (winner == 2) begin
            m_wen = (lsu_waddr != 5'd0); m_waddr = lsu_waddr; m_wdata = lsu_wdata; m_last_lsu = 1'b1;
        end else begin
            m_wen = 1'b0;
        end
        #1;
        chk("rf_wen", rf_wen, 32'(m_wen));
        chk("rf_waddr", rf_waddr, 32'(m_waddr));
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("wb_cnt", wb_cnt, m_cnt);
    endtask

    initial begin
        int ex_left, lsu_left, k;
        model_reset();

        // reset state
        #12;
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_wb_cnt", wb_cnt, 0);
        chk("rst_busy1", sb_busy1, 0);
        rst = 1'b0;
        cycle();

        // conflict: ex then lsu alternately, 3 requests each
        ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hA000_0000;
        lsu_valid = 1'b1; lsu_waddr = 5'd6; lsu_wdata = 32'hB000_0000;
        ex_left = 3; lsu_left = 3;
        for (k = 0; k < 6; k++) begin
            cycle();
            chk("conf_ex_rdy", obs_ex_rdy, 32'(k % 2 == 0));
            chk("conf_lsu_rdy", obs_lsu_rdy, 32'(k % 2 == 1));
            chk("conf_waddr", rf_waddr, (k % 2 == 0) ? 32'd5 : 32'd6);
            if (obs_ex_rdy)  begin ex_left--;  ex_wdata  = $urandom; ex_valid  = (ex_left > 0);  end
            if (obs_lsu_rdy) begin lsu_left--; lsu_wdata = $urandom; lsu_valid = (lsu_left > 0); end
        end
        cycle();
        chk("conf_wb_cnt", wb_cnt, 6);

        // stall with both valid, then ex wins first
        wb_stall = 1'b1;
        ex_valid = 1'b1; ex_waddr = 5'd5;
        lsu_valid = 1'b1; lsu_waddr = 5'd6;
        for (k = 0; k < 3; k++) begin
            cycle();
            chk("stall_ex_rdy", obs_ex_rdy, 0);
            chk("stall_lsu_rdy", obs_lsu_rdy, 0);
            chk("stall_rf_wen", rf_wen, 0);
        end
        wb_stall = 1'b0;
        cycle();
        chk("release_ex_first", obs_ex_rdy, 1);
        ex_valid = 1'b0;
        cycle();
        chk("release_lsu_next", obs_lsu_rdy, 1);
        lsu_valid = 1'b0;

        // write to x0 is accepted but does not retire
        ex_valid = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'hDEAD_BEEF;
        cycle();
        chk("x0_ex_rdy", obs_ex_rdy, 1);
        chk("x0_rf_wen", rf_wen, 0);
        ex_valid = 1'b0;
        cycle();
        chk("x0_wb_cnt", wb_cnt, 8);

        // scoreboard set then clear on write-back of 7
        sb_raddr1 = 5'd7; sb_raddr2 = 5'd0;
        sb_set = 1'b1; sb_set_addr = 5'd7;
        cycle();
        sb_set = 1'b0;
        cycle();
        chk("sb_busy_after_set", obs_b1, 1);
        ex_valid = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h0000_0777;
        cycle();
        chk("sb_busy_on_accept", obs_b1, 1);
        ex_valid = 1'b0;
        cycle();
`ifdef YSYX_25030081_WB_BYPASS_EN
        chk("sb_busy_during_wen", obs_b1, 0);
`else
        chk("sb_busy_during_wen", obs_b1, 1);
`endif
        cycle();
        chk("sb_busy_cleared", obs_b1, 0);

        // same-cycle set during write-back keeps it busy
        sb_set = 1'b1; sb_set_addr = 5'd7;
        cycle();
        sb_set = 1'b0;
        ex_valid = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h0000_0778;
        cycle();
        ex_valid = 1'b0;
        sb_set = 1'b1; sb_set_addr = 5'd7;
        cycle();
        chk("sb_set_wins_during", obs_b1, 1);
        sb_set = 1'b0;
        cycle();
        chk("sb_set_wins_after", obs_b1, 1);

        // write of 0x1234 to x3 seen through rs2
        sb_set = 1'b1; sb_set_addr = 5'd3;
        cycle();
        sb_set = 1'b0;
        ex_valid = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h0000_1234;
        cycle();
        ex_valid = 1'b0;
        sb_raddr2 = 5'd3;
        cycle();
`ifdef YSYX_25030081_WB_BYPASS_EN
        chk("byp_busy2", obs_b2, 0);
`else
        chk("byp_busy2", obs_b2, 1);
`endif

        // asynchronous reset with a write pending
        sb_set = 1'b1; sb_set_addr = 5'd8;
        cycle();
        sb_set = 1'b0;
        ex_valid = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h0000_0999;
        cycle();
        ex_valid = 1'b0;
        sb_raddr1 = 5'd7; sb_raddr2 = 5'd8;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_rf_wen", rf_wen, 0);
        chk("arst_wb_cnt", wb_cnt, 0);
        chk("arst_busy1", sb_busy1, 0);
        chk("arst_busy2", sb_busy2, 0);
        model_reset();
        #2;
        rst = 1'b0;

        // randomized traffic honouring the hold-until-ready rule
        for (int n = 0; n < 400; n++) begin
            if (!ex_valid && ($urandom_range(0, 2) != 0)) begin
                ex_valid = 1'b1; ex_waddr = 5'($urandom_range(0, 7)); ex_wdata = $urandom;
            end
            if (!lsu_valid && ($urandom_range(0, 2) != 0)) begin
                lsu_valid = 1'b1; lsu_waddr = 5'($urandom_range(0, 7)); lsu_wdata = $urandom;
            end
            wb_stall    = ($urandom_range(0, 5) == 0);
            sb_set      = ($urandom_range(0, 2) == 0);
            sb_set_addr = 5'($urandom_range(0, 7));
            sb_raddr1   = 5'($urandom_range(0, 7));
            sb_raddr2   = 5'($urandom_range(0, 7));
            cycle();
            if (obs_ex_rdy)  ex_valid  = 1'b0;
            if (obs_lsu_rdy) lsu_valid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_25030081_rf_wb_arb.md
Name: ysyx_25030081_rf_wb_arb

Overview:
Write-back arbiter and scoreboard for the single-write-port 32-entry GPR file. It shares the one write port between two producers: ex (ALU/CSR results) and lsu (load data). Grants are round-robin, and each granted write is registered for one cycle before it drives the register-file write port. It also tracks which GPRs have an outstanding producer, so decode can stall on RAW hazards.

Parameters:
RF_ADDR_WIDTH, 5, GPR index width; 2**RF_ADDR_WIDTH entries
DATA_WIDTH, 32, write data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wb_stall  in  1  freeze: no grants while high
ex_valid  in  1  ex write request
ex_ready  out  1  ex request accepted this cycle
ex_waddr  in  RF_ADDR_WIDTH  ex destination
ex_wdata  in  DATA_WIDTH  ex data
lsu_valid  in  1  lsu write request
lsu_ready  out  1  lsu request accepted this cycle
lsu_waddr  in  RF_ADDR_WIDTH  lsu destination
lsu_wdata  in  DATA_WIDTH  lsu data
rf_wen  out  1  register-file write enable
rf_waddr  out  RF_ADDR_WIDTH  register-file write address
rf_wdata  out  DATA_WIDTH  register-file write data
sb_set  in  1  decode issues an instruction with a destination
sb_set_addr  in  RF_ADDR_WIDTH  its rd
sb_raddr1  in  RF_ADDR_WIDTH  rs1 query
sb_raddr2  in  RF_ADDR_WIDTH  rs2 query
sb_busy1  out  1  rs1 has a pending producer
sb_busy2  out  1  rs2 has a pending producer
wb_cnt  out  32  count of retired non-x0 writes

Behaviour:
- Clock and reset: single clock domain. rst asynchronous, active-high, on clk/rst as named above.
- Reset values:
  - rf_wen=0, rf_waddr=0, rf_wdata=0, wb_cnt=0.
  - Busy vector all 0.
  - last_grant=LSU, so ex wins the first conflict.
- Grant (combinational from current inputs and last_grant):
  - wb_stall=1: both ready outputs are 0.
  - Only one producer valid: that producer is granted.
  - Both valid: the producer not equal to last_grant is granted.
  - ready = grant. A transfer occurs when valid & ready. At most one transfer per cycle.
  - last_grant updates only on a transfer.
- Handshake rules:
  - A producer holds valid, waddr and wdata stable until ready.
  - ready never depends on the producer's own data.
- Output register:
  - A transfer in cycle N drives rf_wen/rf_waddr/rf_wdata in cycle N+1, so data is architecturally visible at the N+2 edge.
  - With no transfer, rf_wen=0 and rf_waddr/rf_wdata hold their previous values.
  - A transfer with waddr=0 is accepted but yields rf_wen=0.
- wb_cnt: increments by 1 on each rf_wen=1 cycle; wraps 0xFFFFFFFF to 0.
- Scoreboard:
  - busy[sb_set_addr] is set on sb_set when sb_set_addr!=0.
  - busy[rf_waddr] is cleared on rf_wen.
  - Set and clear of the same register in the same cycle: set wins (new producer).
  - busy[0] is constant 0.
  - sb_busyN = busy[sb_raddrN], pure combinational.
  - No forwarding: a register being cleared this cycle still reads busy.
- Reset mid-operation:
  - A pending output write is discarded (rf_wen=0 immediately).
  - All busy bits clear and last_grant returns to LSU.

Optional Feature:
- Macro: YSYX_25030081_WB_BYPASS_EN.
- Defined:
  - sb_busyN is forced 0 when rf_wen=1 and rf_waddr==sb_raddrN and no same-cycle sb_set targets that register.
  - Adds bypass_data1/bypass_data2 outputs (DATA_WIDTH) equal to rf_wdata, valid under that same condition, so decode can consume the value one cycle early.
- Undefined: no bypass ports; busy is the raw scoreboard bit.

Test Plan:
- Reset: assert rst mid-cycle with an rf write pending -> rf_wen=0, wb_cnt=0 and sb_busy1=sb_busy2=0 immediately, without waiting for a clock edge.
- Conflict: ex_valid and lsu_valid both high for 4 cycles, ex_waddr=5, lsu_waddr=6 -> grants ex,lsu,ex,lsu; rf_waddr sequence 5,6,5,6 one cycle later; wb_cnt=4.
- Stall: both valid with wb_stall=1 for 3 cycles -> both ready=0, rf_wen=0; after release, ex is granted first.
- x0 write: ex_valid with ex_waddr=0, ex_wdata=0xDEADBEEF -> ex_ready=1, next cycle rf_wen=0, wb_cnt unchanged.
- Scoreboard: sb_set with addr 7, then an ex write to 7 accepted -> sb_busy1 (raddr1=7) is 1 until the cycle after rf_wen is asserted for 7. A same-cycle sb_set of 7 during that rf_wen keeps busy=1.
- Bypass (macro defined): rf_wen=1, rf_waddr=3, rf_wdata=0x1234, sb_raddr2=3 -> sb_busy2=0, bypass_data2=0x1234.
